// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction memory request/response channel between fetch unit and imem
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master(output imem_req_valid, imem_req_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave(input imem_req_valid, imem_req_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RISC-V fetch stage with credit-limited imem requests, instruction FIFO and redirect flush
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallF,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic                   validF,
  output logic [31:0]            instrF,
  output logic [31:0]            PCF,
  output logic [31:0]            PCPlus4F
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MAX_OUTST + 1);
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [IW-1:0] inflight_q, inflight_d, kill_q, kill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   pc_buf_q [FIFO_DEPTH];
  logic [31:0]   instr_buf_q [FIFO_DEPTH];
  logic          pop, push, acc, rsp;
  logic [31:0]   used;
  always_comb begin
    validF = cnt_q != '0;
    pop = validF && !stallF && !redirect;
    rsp = imem.imem_rsp_valid;
    push = rsp && kill_q == '0 && !redirect;
    // credits count buffered entries plus live (not killed) requests so a push always has room
    used = 32'(cnt_q) - 32'(pop) + 32'(inflight_q) - 32'(kill_q);
    imem.imem_req_valid = !rst && !redirect && 32'(inflight_q) < 32'(MAX_OUTST) && used < 32'(FIFO_DEPTH);
    imem.imem_req_addr = fetch_pc_q;
    acc = imem.imem_req_valid && imem.imem_req_ready;
    inflight_d = inflight_q + IW'(acc) - IW'(rsp);
    kill_d = redirect ? inflight_d : kill_q - IW'(rsp && kill_q != '0);
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + (acc ? 32'd4 : 32'd0);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d = redirect ? '0 : rd_q + AW'(pop);
    wr_d = redirect ? '0 : wr_q + AW'(push);
    instrF = validF ? instr_buf_q[rd_q] : 32'h0000_0013;
    PCF = validF ? pc_buf_q[rd_q] : '0;
    PCPlus4F = validF ? pc_buf_q[rd_q] + 32'd4 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      kill_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      kill_q <= kill_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf_q[wr_q] <= fetch_pc_q - 32'(inflight_q - kill_q) * 32'd4;
      instr_buf_q[wr_q] <= imem.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized bench for if_fetch_unit against a queue-based reference model and imem model
module tb_if_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO = 4;
  localparam logic [31:0] RPC = 32'h100;
  typedef struct { logic [31:0] pc; logic [31:0] data; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit alive; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fent_t;
  logic clk = 0, rst = 1, stallF = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic validF;
  logic [31:0] instrF, PCF, PCPlus4F;
  if_fetch_unit_if bus();
  if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(bus), .validF(validF), .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, lat_fix = 1;
  bit lat_rand = 0;
  logic [31:0] npc;
  mreq_t mq[$];
  inf_t iq[$];
  fent_t fq[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    redirect = 0;
    stallF = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_req_ready = 0;
    #1;
    chk("rst_validF", validF, 0);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_instrF", instrF, 32'h13);
    chk("rst_PCF", PCF, 0);
    chk("rst_PCPlus4F", PCPlus4F, 0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    fq.delete();
    iq.delete();
    mq.delete();
    npc = RPC;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic rsp, exp_valid, pop, exp_rv;
    int live, lat, due;
    mreq_t m;
    inf_t e;
    stallF = st;
    redirect = rd;
    redirect_pc = rpc;
    bus.imem_req_ready = rdy;
    rsp = mq.size() > 0 && mq[0].due == cyc;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data = rsp ? mq[0].data : $urandom;
    #1;
    exp_valid = fq.size() > 0;
    chk("validF", validF, exp_valid);
    if (exp_valid) begin
      chk("PCF", PCF, fq[0].pc);
      chk("instrF", instrF, fq[0].instr);
      chk("PCPlus4F", PCPlus4F, fq[0].pc + 32'd4);
    end else begin
      chk("PCF_idle", PCF, 0);
      chk("instrF_idle", instrF, 32'h13);
      chk("PCPlus4F_idle", PCPlus4F, 0);
    end
    pop = exp_valid && !st && !rd;
    live = 0;
    foreach (iq[i]) if (iq[i].alive) live++;
    exp_rv = !rd && iq.size() < MAXO && (int'(fq.size()) - int'(pop) + live) < DEPTH;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, npc);
    if (pop) void'(fq.pop_front());
    if (rsp) begin
      m = mq.pop_front();
      e = iq.pop_front();
      if (e.alive && !rd) begin
        chk("no_overflow", fq.size() < DEPTH, 1);
        fq.push_back('{pc: e.pc, instr: m.data});
      end
    end
    if (rd) begin
      fq.delete();
      foreach (iq[i]) iq[i].alive = 0;
      npc = rpc;
    end
    if (exp_rv && rdy) begin
      lat = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
      due = cyc + lat;
      if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
      mq.push_back('{pc: npc, data: mem_word(npc), due: due});
      iq.push_back('{pc: npc, alive: 1});
      npc += 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    int k;
    @(negedge clk);
    do_reset();
    // steady flow from RESET_PC with a one-cycle always-ready memory
    lat_fix = 1;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // redirect with two requests outstanding on a three-cycle memory
    do_reset();
    lat_fix = 3;
    k = 0;
    while (iq.size() < 2 && k < 20) begin step(0, 0, 0, 1); k++; end
    chk("s3_two_inflight", iq.size(), 2);
    step(0, 1, 32'h200, 1);
    chk("s3_flushed", validF, 0);
    k = 0;
    while (!validF && k < 20) begin step(0, 0, 0, 1); k++; end
    chk("s3_first_pc", PCF, 32'h200);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    // redirect together with a response and a stall; unaligned target kept as is
    lat_fix = 1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    k = 0;
    while (!(mq.size() > 0 && mq[0].due == cyc) && k < 10) begin step(0, 0, 0, 1); k++; end
    chk("s4_rsp_due", k < 10, 1);
    step(1, 1, 32'h342, 1);
    chk("s4_flushed", validF, 0);
    #1;
    chk("s4_addr", bus.imem_req_addr, 32'h342);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    // random ready, latency, stalls and redirects
    lat_rand = 1;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           32'h1000 + ($urandom_range(0, 63) << 2), $urandom_range(0, 1) == 1);
    lat_rand = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    // reset mid-burst with three entries buffered
    lat_fix = 1;
    k = 0;
    while (fq.size() != 3 && k < 10) begin step(1, 0, 0, 1); k++; end
    chk("s6_three_buffered", fq.size(), 3);
    chk("s6_validF_before", validF, 1);
    do_reset();
    #1;
    chk("s6_restart_addr", bus.imem_req_addr, RPC);
    chk("s6_validF_after", validF, 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
